spw_rx_fifo_wr: RTL and testbench



---
 rtl/spw_rx_pkg.sv | 16 +
 rtl/spw_rx_fifo_wr_if.sv | 33 +++
 rtl/spw_sync_2ff.sv | 27 ++
 rtl/spw_rx_fifo_wr.sv | 96 +++++++++
 tb/tb_spw_rx_fifo_wr.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/spw_rx_pkg.sv
// Shared constants and helpers for the SpaceWire receive FIFO write half.
package spw_rx_pkg;

  localparam int unsigned SPW_AWIDTH = 6;
  localparam int unsigned SPW_DWIDTH = 9;

  // Control characters as presented by the decoder (bit 8 = control flag).
  localparam logic [8:0] SPW_EOP = 9'h100;
  localparam logic [8:0] SPW_EEP = 9'h101;

  // Binary to reflected Gray code; callers truncate to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/spw_rx_fifo_wr_if.sv
// Character and pointer bus between the receive decoder / system read half
// and the receive-clock write half of the FIFO.
interface spw_rx_fifo_wr_if
  import spw_rx_pkg::*;
#(
  parameter int unsigned AWIDTH = SPW_AWIDTH,
  parameter int unsigned DWIDTH = SPW_DWIDTH
) ();

  logic [DWIDTH-1:0] rx_data_flag;
  logic              rx_buffer_write;
  logic [AWIDTH:0]   rd_ptr_gray;
  logic [AWIDTH-1:0] rd_addr;
  logic [DWIDTH-1:0] rd_data;
  logic [AWIDTH:0]   wr_ptr_gray;
  logic              fifo_full;
  logic              overflow_error;
  logic [7:0]        eop_count;
  logic [7:0]        eep_count;

  // Side that drives characters and the read pointer/address.
  modport master (
    output rx_data_flag, rx_buffer_write, rd_ptr_gray, rd_addr,
    input  rd_data, wr_ptr_gray, fifo_full, overflow_error, eop_count, eep_count
  );

  // FIFO write half.
  modport slave (
    input  rx_data_flag, rx_buffer_write, rd_ptr_gray, rd_addr,
    output rd_data, wr_ptr_gray, fifo_full, overflow_error, eop_count, eep_count
  );

endinterface

// File: rtl/spw_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded bus crossing into posedge_clk.
module spw_sync_2ff #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             posedge_clk,
  input  logic             rx_resetn,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge posedge_clk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/spw_rx_fifo_wr.sv
// Write half of the SpaceWire receive character FIFO (receive clock domain).
// Captures one character per write-request level, exports a Gray write
// pointer and an asynchronous read port, flags overflow, counts EOP/EEP.
module spw_rx_fifo_wr
  import spw_rx_pkg::*;
#(
  parameter int unsigned AWIDTH = SPW_AWIDTH,
  parameter int unsigned DWIDTH = SPW_DWIDTH
) (
  input logic             posedge_clk,
  input logic             rx_resetn,
  spw_rx_fifo_wr_if.slave bus
);

  localparam int unsigned PW    = AWIDTH + 1;
  localparam int unsigned DEPTH = 1 << AWIDTH;

  logic              wr_q,           wr_d;
  logic [PW-1:0]     wr_bin_q,       wr_bin_d;
  logic [PW-1:0]     wr_ptr_gray_q,  wr_ptr_gray_d;
  logic              overflow_q,     overflow_d;
  logic [7:0]        eop_count_q,    eop_count_d;
  logic [7:0]        eep_count_q,    eep_count_d;

  logic [PW-1:0]     rd_sync;
  logic [PW-1:0]     full_ptr_c;
  logic              wr_req_c;
  logic              fifo_full_c;
  logic              wr_accept_c;

  logic [DWIDTH-1:0] mem_q [DEPTH];

  spw_sync_2ff #(.WIDTH(PW)) u_rd_sync (
    .posedge_clk (posedge_clk),
    .rx_resetn   (rx_resetn),
    .async_in    (bus.rd_ptr_gray),
    .sync_out    (rd_sync)
  );

  // Edge detect, full compare against the synchronized read pointer, and
  // next-state for pointers, overflow flag and marker counters.
  always_comb begin
    wr_d          = bus.rx_buffer_write;
    wr_bin_d      = wr_bin_q;
    wr_ptr_gray_d = wr_ptr_gray_q;
    overflow_d    = overflow_q;
    eop_count_d   = eop_count_q;
    eep_count_d   = eep_count_q;

    wr_req_c    = bus.rx_buffer_write & ~wr_q;
    full_ptr_c  = {~rd_sync[AWIDTH:AWIDTH-1], rd_sync[AWIDTH-2:0]};
    fifo_full_c = (wr_ptr_gray_q == full_ptr_c);
    wr_accept_c = wr_req_c & ~fifo_full_c;

    if (wr_accept_c) begin
      wr_bin_d      = wr_bin_q + PW'(1);
      wr_ptr_gray_d = PW'(bin2gray(32'(wr_bin_d)));
      if (bus.rx_data_flag == DWIDTH'(SPW_EOP)) eop_count_d = eop_count_q + 8'd1;
      if (bus.rx_data_flag == DWIDTH'(SPW_EEP)) eep_count_d = eep_count_q + 8'd1;
    end else if (wr_req_c) begin
      overflow_d = 1'b1;
    end
  end

  // Control and pointer state registers.
  always_ff @(posedge posedge_clk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      wr_q          <= 1'b0;
      wr_bin_q      <= '0;
      wr_ptr_gray_q <= '0;
      overflow_q    <= 1'b0;
      eop_count_q   <= '0;
      eep_count_q   <= '0;
    end else begin
      wr_q          <= wr_d;
      wr_bin_q      <= wr_bin_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      overflow_q    <= overflow_d;
      eop_count_q   <= eop_count_d;
      eep_count_q   <= eep_count_d;
    end
  end

  // Character storage; contents are not reset, pointers define validity.
  always_ff @(posedge posedge_clk) begin
    if (wr_accept_c) mem_q[wr_bin_q[AWIDTH-1:0]] <= bus.rx_data_flag;
  end

  assign bus.rd_data        = mem_q[bus.rd_addr];
  assign bus.wr_ptr_gray    = wr_ptr_gray_q;
  assign bus.fifo_full      = fifo_full_c;
  assign bus.overflow_error = overflow_q;
  assign bus.eop_count      = eop_count_q;
  assign bus.eep_count      = eep_count_q;

endmodule

// File: tb/tb_spw_rx_fifo_wr.sv
// Directed bench for the SpaceWire receive FIFO write half.
module tb_spw_rx_fifo_wr;

  logic posedge_clk;
  logic rx_resetn;

  spw_rx_fifo_wr_if #(.AWIDTH(6), .DWIDTH(9)) bus ();

  spw_rx_fifo_wr #(.AWIDTH(6), .DWIDTH(9)) dut (
    .posedge_clk (posedge_clk),
    .rx_resetn   (rx_resetn),
    .bus         (bus)
  );

  initial posedge_clk = 1'b0;
  always #5 posedge_clk = ~posedge_clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [8:0] data;
    logic [6:0] gray;
    logic [7:0] eop;
    logic [7:0] eep;
    logic [5:0] addr;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One request: level high for hold clocks, then low for one clock.
  task automatic do_write(input logic [8:0] data, input int hold);
    @(negedge posedge_clk);
    bus.rx_data_flag    = data;
    bus.rx_buffer_write = 1'b1;
    repeat (hold) @(negedge posedge_clk);
    bus.rx_buffer_write = 1'b0;
    @(negedge posedge_clk);
  endtask

  task automatic peek(input string name, input logic [5:0] addr, input logic [8:0] exp);
    bus.rd_addr = addr;
    #1;
    check(name, 32'(bus.rd_data), 32'(exp));
  endtask

  task automatic check_zero_state(input string tag);
    check({tag, "_gray"},  32'(bus.wr_ptr_gray),    32'h0);
    check({tag, "_full"},  32'(bus.fifo_full),      32'h0);
    check({tag, "_ovf"},   32'(bus.overflow_error), 32'h0);
    check({tag, "_eop"},   32'(bus.eop_count),      32'h0);
    check({tag, "_eep"},   32'(bus.eep_count),      32'h0);
  endtask

  initial begin
    int cyc;
    bit freed;

    vecs[0] = '{data: 9'h100, gray: 7'h03, eop: 8'd1, eep: 8'd0, addr: 6'd1};
    vecs[1] = '{data: 9'h101, gray: 7'h02, eop: 8'd1, eep: 8'd1, addr: 6'd2};
    vecs[2] = '{data: 9'h100, gray: 7'h06, eop: 8'd2, eep: 8'd1, addr: 6'd3};
    vecs[3] = '{data: 9'h105, gray: 7'h07, eop: 8'd2, eep: 8'd1, addr: 6'd4};

    rx_resetn           = 1'b0;
    bus.rx_data_flag    = '0;
    bus.rx_buffer_write = 1'b0;
    bus.rd_ptr_gray     = '0;
    bus.rd_addr         = '0;

    // Reset state
    #2;
    check_zero_state("reset");
    @(negedge posedge_clk);
    rx_resetn = 1'b1;

    // Held level gives exactly one write
    do_write(9'h041, 3);
    check("held_gray", 32'(bus.wr_ptr_gray), 32'h01);
    peek("held_mem0", 6'd0, 9'h041);

    // Marker table
    for (int i = 0; i < 4; i++) begin
      do_write(vecs[i].data, 1);
      check($sformatf("vec%0d_gray", i), 32'(bus.wr_ptr_gray), 32'(vecs[i].gray));
      check($sformatf("vec%0d_eop", i),  32'(bus.eop_count),   32'(vecs[i].eop));
      check($sformatf("vec%0d_eep", i),  32'(bus.eep_count),   32'(vecs[i].eep));
      check($sformatf("vec%0d_full", i), 32'(bus.fifo_full),   32'h0);
      peek($sformatf("vec%0d_mem", i), vecs[i].addr, vecs[i].data);
    end

    // Fill to 63 entries, then the 64th makes it full
    for (int i = 0; i < 58; i++) do_write(9'(8'h10 + 8'(i)), 1);
    check("fill63_gray", 32'(bus.wr_ptr_gray), 32'h20);
    check("fill63_full", 32'(bus.fifo_full),   32'h0);
    do_write(9'h0F0, 1);
    check("fill64_gray", 32'(bus.wr_ptr_gray), 32'h60);
    check("fill64_full", 32'(bus.fifo_full),   32'h1);
    check("fill64_ovf",  32'(bus.overflow_error), 32'h0);
    peek("fill64_mem63", 6'd63, 9'h0F0);

    // 65th write is dropped
    do_write(9'h0AA, 1);
    check("drop_ovf",  32'(bus.overflow_error), 32'h1);
    check("drop_gray", 32'(bus.wr_ptr_gray),    32'h60);
    check("drop_eop",  32'(bus.eop_count),      32'h2);
    peek("drop_mem0", 6'd0, 9'h041);

    // Reader frees one slot; full clears after the synchronizer
    @(negedge posedge_clk);
    bus.rd_ptr_gray = 7'h01;
    cyc   = 0;
    freed = 1'b0;
    while (!freed && cyc < 4) begin
      @(negedge posedge_clk);
      cyc++;
      if (!bus.fifo_full) freed = 1'b1;
    end
    check("free_cycles", 32'(cyc), 32'd2);

    // Wrap write lands at slot 0 and fills again
    do_write(9'h055, 1);
    check("wrap_gray", 32'(bus.wr_ptr_gray),    32'h61);
    check("wrap_full", 32'(bus.fifo_full),      32'h1);
    check("wrap_ovf",  32'(bus.overflow_error), 32'h1);
    peek("wrap_mem0", 6'd0, 9'h055);

    // Reset mid-fill
    @(negedge posedge_clk);
    bus.rd_ptr_gray = '0;
    rx_resetn = 1'b0;
    #1;
    check_zero_state("rst2");
    @(negedge posedge_clk);
    rx_resetn = 1'b1;
    for (int i = 0; i < 10; i++) do_write((i == 4) ? 9'h100 : 9'(8'h30 + 8'(i)), 1);
    check("mid_gray", 32'(bus.wr_ptr_gray), 32'h0F);
    check("mid_eop",  32'(bus.eop_count),   32'h1);
    @(negedge posedge_clk);
    rx_resetn = 1'b0;
    #1;
    check_zero_state("rst3");
    @(negedge posedge_clk);
    rx_resetn = 1'b1;
    do_write(9'h077, 1);
    check("post_gray", 32'(bus.wr_ptr_gray), 32'h01);
    peek("post_mem0", 6'd0, 9'h077);
    peek("post_mem1", 6'd1, 9'h031);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
